// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter and fetch sequencer with start/stall/halt/branch redirect
// Ports: clk/reset (async, active-high); start_i+start_addr_i launch a program from IDLE/HALT;
// stall_i freezes RUN; branch_taken_i+target_i redirect; halt_i stops; pc_o/valid_o/done_o
// report fetch state; instr_count_o counts retired instructions (saturating).
module fetch_pc_unit #(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [PC_W-1:0]  start_addr_i,
  input  logic             stall_i,
  input  logic             branch_taken_i,
  input  logic [PC_W-1:0]  target_i,
  input  logic             halt_i,
  output logic [PC_W-1:0]  pc_o,
  output logic             valid_o,
  output logic             done_o,
  output logic [CNT_W-1:0] instr_count_o
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             advance, go;
  assign valid_o       = state_q == RUN;
  assign advance       = valid_o & ~stall_i;
  assign go            = start_i & (state_q != RUN);
  assign pc_o          = pc_q;
  assign done_o        = done_q;
  assign instr_count_o = cnt_q;
  // halt outranks branch: a halting instruction keeps pc pointing at itself
  always_comb begin
    state_d = go ? RUN : (advance & halt_i) ? HALT : state_q;
    pc_d    = go ? start_addr_i
            : (advance & ~halt_i) ? (branch_taken_i ? target_i : pc_q + 1'b1)
            : pc_q;
    cnt_d   = go ? '0 : (advance & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
    done_d  = go ? 1'b0 : (advance & halt_i) ? 1'b1 : done_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: scoreboard bench for fetch_pc_unit
module tb_fetch_pc_unit;
  logic        clk = 0, reset = 0, start_i = 0, stall_i = 0, branch_taken_i = 0, halt_i = 0;
  logic [7:0]  start_addr_i = 0, target_i = 0, pc_o;
  logic        valid_o, done_o;
  logic [15:0] instr_count_o;
  typedef struct packed {logic st; logic [7:0] a; logic sl, br; logic [7:0] t; logic h;} in_t;
  typedef struct packed {logic [7:0] pc; logic v, d; logic [15:0] c;} exp_t;
  exp_t q[$];
  exp_t e;
  int total = 0, passed = 0;
  localparam in_t NOP = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
  fetch_pc_unit dut (
    .clk(clk), .reset(reset), .start_i(start_i), .start_addr_i(start_addr_i),
    .stall_i(stall_i), .branch_taken_i(branch_taken_i), .target_i(target_i),
    .halt_i(halt_i), .pc_o(pc_o), .valid_o(valid_o), .done_o(done_o),
    .instr_count_o(instr_count_o)
  );
  always #5 clk = ~clk;
  function automatic in_t st(logic [7:0] a);
    st = NOP; st.st = 1'b1; st.a = a;
  endfunction
  function automatic in_t br(logic [7:0] t, logic sl, logic h);
    br = NOP; br.br = 1'b1; br.t = t; br.sl = sl; br.h = h;
  endfunction
  task automatic apply(in_t s);
    {start_i, start_addr_i, stall_i, branch_taken_i, target_i, halt_i} = s;
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    reset = 1; #1;
    @(posedge clk); #1 reset = 0;
  endtask
  task automatic test_reset();
    #2 reset = 1;
    q.push_back('{8'h00, 1'b0, 1'b0, 16'h0});
    #1 e = q.pop_front(); total++;
    if ({pc_o, valid_o, done_o, instr_count_o} !== e)
      $display("FAIL reset_async: got pc=%h v=%b d=%b cnt=%h want pc=%h v=%b d=%b cnt=%h", pc_o, valid_o, done_o, instr_count_o, e.pc, e.v, e.d, e.c);
    else passed++;
    @(posedge clk); #1 reset = 0;
    for (int i = 0; i < 3; i++) begin
      q.push_back('{8'h00, 1'b0, 1'b0, 16'h0});
      apply(br(8'h44, 1'b0, i == 1));
      e = q.pop_front(); total++;
      if ({pc_o, valid_o, done_o, instr_count_o} !== e)
        $display("FAIL idle_ignore[%0d]: got pc=%h v=%b d=%b cnt=%h want pc=%h v=%b d=%b cnt=%h", i, pc_o, valid_o, done_o, instr_count_o, e.pc, e.v, e.d, e.c);
      else passed++;
    end
  endtask
  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      q.push_back('{8'(i), 1'b1, 1'b0, 16'(i)});
      apply(i == 0 ? st(8'h00) : NOP);
      e = q.pop_front(); total++;
      if ({pc_o, valid_o, done_o, instr_count_o} !== e)
        $display("FAIL sequential[%0d]: got pc=%h v=%b d=%b cnt=%h want pc=%h v=%b d=%b cnt=%h", i, pc_o, valid_o, done_o, instr_count_o, e.pc, e.v, e.d, e.c);
      else passed++;
    end
  endtask
  task automatic test_branch();
    in_t  s[8];
    exp_t x[8];
    do_reset();
    for (int i = 0; i < 4; i++) begin s[i] = i == 0 ? st(8'h00) : NOP; x[i] = '{8'(i), 1'b1, 1'b0, 16'(i)}; end
    s[4] = br(8'h25, 1'b0, 1'b0); x[4] = '{8'h25, 1'b1, 1'b0, 16'd4};
    s[5] = NOP;                   x[5] = '{8'h26, 1'b1, 1'b0, 16'd5};
    s[6] = br(8'h26, 1'b0, 1'b0); x[6] = '{8'h26, 1'b1, 1'b0, 16'd6};
    s[7] = br(8'h26, 1'b0, 1'b0); x[7] = '{8'h26, 1'b1, 1'b0, 16'd7};
    for (int i = 0; i < 8; i++) begin
      q.push_back(x[i]);
      apply(s[i]);
      e = q.pop_front(); total++;
      if ({pc_o, valid_o, done_o, instr_count_o} !== e)
        $display("FAIL branch[%0d]: got pc=%h v=%b d=%b cnt=%h want pc=%h v=%b d=%b cnt=%h", i, pc_o, valid_o, done_o, instr_count_o, e.pc, e.v, e.d, e.c);
      else passed++;
    end
  endtask
  task automatic test_stall_branch();
    in_t  s[7];
    exp_t x[7];
    do_reset();
    for (int i = 0; i < 4; i++) begin s[i] = i == 0 ? st(8'h00) : NOP; x[i] = '{8'(i), 1'b1, 1'b0, 16'(i)}; end
    s[4] = br(8'h25, 1'b1, 1'b0); x[4] = '{8'h03, 1'b1, 1'b0, 16'd3};
    s[5] = br(8'h25, 1'b1, 1'b0); x[5] = '{8'h03, 1'b1, 1'b0, 16'd3};
    s[6] = br(8'h25, 1'b0, 1'b0); x[6] = '{8'h25, 1'b1, 1'b0, 16'd4};
    for (int i = 0; i < 7; i++) begin
      q.push_back(x[i]);
      apply(s[i]);
      e = q.pop_front(); total++;
      if ({pc_o, valid_o, done_o, instr_count_o} !== e)
        $display("FAIL stall_branch[%0d]: got pc=%h v=%b d=%b cnt=%h want pc=%h v=%b d=%b cnt=%h", i, pc_o, valid_o, done_o, instr_count_o, e.pc, e.v, e.d, e.c);
      else passed++;
    end
  endtask
  task automatic test_halt();
    in_t  s[6];
    exp_t x[6];
    do_reset();
    s[0] = st(8'h10);             x[0] = '{8'h10, 1'b1, 1'b0, 16'd0};
    s[1] = br(8'h55, 1'b0, 1'b1); x[1] = '{8'h10, 1'b0, 1'b1, 16'd1};
    s[2] = br(8'h66, 1'b0, 1'b1); x[2] = '{8'h10, 1'b0, 1'b1, 16'd1};
    s[3] = br(8'h77, 1'b1, 1'b0); x[3] = '{8'h10, 1'b0, 1'b1, 16'd1};
    s[4] = st(8'h0B);             x[4] = '{8'h0B, 1'b1, 1'b0, 16'd0};
    s[5] = NOP;                   x[5] = '{8'h0C, 1'b1, 1'b0, 16'd1};
    for (int i = 0; i < 6; i++) begin
      q.push_back(x[i]);
      apply(s[i]);
      e = q.pop_front(); total++;
      if ({pc_o, valid_o, done_o, instr_count_o} !== e)
        $display("FAIL halt[%0d]: got pc=%h v=%b d=%b cnt=%h want pc=%h v=%b d=%b cnt=%h", i, pc_o, valid_o, done_o, instr_count_o, e.pc, e.v, e.d, e.c);
      else passed++;
    end
  endtask
  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q.push_back('{8'(8'hFE + i), 1'b1, 1'b0, 16'(i)});
      apply(i == 0 ? st(8'hFE) : NOP);
      e = q.pop_front(); total++;
      if ({pc_o, valid_o, done_o, instr_count_o} !== e)
        $display("FAIL wrap[%0d]: got pc=%h v=%b d=%b cnt=%h want pc=%h v=%b d=%b cnt=%h", i, pc_o, valid_o, done_o, instr_count_o, e.pc, e.v, e.d, e.c);
      else passed++;
    end
  endtask
  task automatic test_reset_mid_run();
    do_reset();
    apply(st(8'h30));
    for (int i = 0; i < 4; i++) begin
      q.push_back('{8'(8'h31 + i), 1'b1, 1'b0, 16'(i + 1)});
      apply(i == 2 ? st(8'h77) : NOP);
      e = q.pop_front(); total++;
      if ({pc_o, valid_o, done_o, instr_count_o} !== e)
        $display("FAIL run_start_ignored[%0d]: got pc=%h v=%b d=%b cnt=%h want pc=%h v=%b d=%b cnt=%h", i, pc_o, valid_o, done_o, instr_count_o, e.pc, e.v, e.d, e.c);
      else passed++;
    end
    #2 reset = 1;
    q.push_back('{8'h00, 1'b0, 1'b0, 16'h0});
    #1 e = q.pop_front(); total++;
    if ({pc_o, valid_o, done_o, instr_count_o} !== e)
      $display("FAIL reset_mid_run: got pc=%h v=%b d=%b cnt=%h want pc=%h v=%b d=%b cnt=%h", pc_o, valid_o, done_o, instr_count_o, e.pc, e.v, e.d, e.c);
    else passed++;
    @(posedge clk); #1 reset = 0;
  endtask
  task automatic test_saturate();
    do_reset();
    apply(st(8'h00));
    for (int i = 0; i < 65534; i++) apply(NOP);
    for (int i = 0; i < 4; i++) begin
      q.push_back('{8'(8'hFE + i), 1'b1, 1'b0, i == 0 ? 16'hFFFE : 16'hFFFF});
      if (i > 0) apply(NOP);
      e = q.pop_front(); total++;
      if ({pc_o, valid_o, done_o, instr_count_o} !== e)
        $display("FAIL saturate[%0d]: got pc=%h v=%b d=%b cnt=%h want pc=%h v=%b d=%b cnt=%h", i, pc_o, valid_o, done_o, instr_count_o, e.pc, e.v, e.d, e.c);
      else passed++;
    end
  endtask
  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall_branch();
    test_halt();
    test_wrap();
    test_reset_mid_run();
    test_saturate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
